// File: rtl/inst_mem_ctrl_pkg.sv
// Shared widths and loader state encodings for the instruction memory block.
// Imported by the RAM and the loader/controller.
package inst_mem_ctrl_pkg;

    localparam int ADDRBUS         = 32;
    localparam int DATABUS         = 32;
    localparam int INST_DEPTH_LOG2 = 10;

    typedef enum logic [1:0] {
        LD_IDLE  = 2'd0,
        LD_LOAD  = 2'd1,
        LD_FLUSH = 2'd2
    } ld_state_e;

endpackage

// File: rtl/inst_mem_ctrl_ram.sv
// Instruction RAM: one synchronous write port, one asynchronous read port.
// Contents are deliberately not reset.
module inst_mem_ctrl_ram
    import inst_mem_ctrl_pkg::*;
#(
    parameter int DATA_W     = DATABUS,
    parameter int DEPTH_LOG2 = INST_DEPTH_LOG2
) (
    input  logic                  clk,
    input  logic                  we,
    input  logic [DEPTH_LOG2-1:0] waddr,
    input  logic [DATA_W-1:0]     wdata,
    input  logic [DEPTH_LOG2-1:0] raddr,
    output logic [DATA_W-1:0]     rdata
);

    logic [DATA_W-1:0] mem [2**DEPTH_LOG2];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/inst_mem_ctrl.sv
// Fetch-side instruction memory with a byte-stream program loader.
// Holds the core in reset while a program is being loaded.
module inst_mem_ctrl
    import inst_mem_ctrl_pkg::*;
#(
    parameter int ADDR_W     = ADDRBUS,
    parameter int DATA_W     = DATABUS,
    parameter int DEPTH_LOG2 = INST_DEPTH_LOG2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [ADDR_W-1:0]     inst_addr,
    output logic [DATA_W-1:0]     inst_data,
    input  logic                  ld_start,
    input  logic [DEPTH_LOG2:0]   ld_words,
    input  logic                  ld_valid,
    input  logic [7:0]            ld_byte,
    output logic                  ld_ready,
    output logic                  ld_done,
    output logic                  busy,
    output logic                  core_rst_n
);

    localparam int CNT_W = DEPTH_LOG2 + 1;

    ld_state_e        state_q, state_d;
    logic [1:0]       byte_cnt_q, byte_cnt_d;
    logic [CNT_W-1:0] word_cnt_q, word_cnt_d;
    logic [CNT_W-1:0] words_q, words_d;
    logic [23:0]      lane_q, lane_d;
    logic             zero_done_q, zero_done_d;
    logic             core_rst_q;

    logic                  ram_we;
    logic [DATA_W-1:0]     ram_wdata;
    logic [DATA_W-1:0]     ram_rdata;
    logic [DEPTH_LOG2-1:0] ram_waddr;
    logic                  addr_in_range;

    always_comb begin
        state_d     = state_q;
        byte_cnt_d  = byte_cnt_q;
        word_cnt_d  = word_cnt_q;
        words_d     = words_q;
        lane_d      = lane_q;
        zero_done_d = 1'b0;
        ram_we      = 1'b0;
        unique case (state_q)
            LD_IDLE, LD_LOAD: begin
                if (ld_start) begin
                    byte_cnt_d = 2'd0;
                    word_cnt_d = '0;
                    lane_d     = '0;
                    words_d    = ld_words;
                    if (ld_words == '0) begin
                        zero_done_d = 1'b1;
                        state_d     = LD_IDLE;
                    end else begin
                        state_d = LD_LOAD;
                    end
                end else if (state_q == LD_LOAD && ld_valid) begin
                    if (byte_cnt_q == 2'd3) begin
                        ram_we     = 1'b1;
                        byte_cnt_d = 2'd0;
                        word_cnt_d = word_cnt_q + CNT_W'(1);
                        if (word_cnt_q == words_q - CNT_W'(1)) begin
                            state_d = LD_FLUSH;
                        end
                    end else begin
                        byte_cnt_d = byte_cnt_q + 2'd1;
                        lane_d[{byte_cnt_q, 3'b000} +: 8] = ld_byte;
                    end
                end
            end
            LD_FLUSH: state_d = LD_IDLE;
            default:  state_d = LD_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= LD_IDLE;
            byte_cnt_q  <= 2'd0;
            word_cnt_q  <= '0;
            words_q     <= '0;
            lane_q      <= '0;
            zero_done_q <= 1'b0;
            core_rst_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            byte_cnt_q  <= byte_cnt_d;
            word_cnt_q  <= word_cnt_d;
            words_q     <= words_d;
            lane_q      <= lane_d;
            zero_done_q <= zero_done_d;
            // Release the core only once the loader is heading back to idle.
            core_rst_q  <= (state_d == LD_IDLE);
        end
    end

    assign ram_wdata = {ld_byte, lane_q};
    assign ram_waddr = word_cnt_q[DEPTH_LOG2-1:0];

    inst_mem_ctrl_ram #(
        .DATA_W     (DATA_W),
        .DEPTH_LOG2 (DEPTH_LOG2)
    ) u_ram (
        .clk   (clk),
        .we    (ram_we),
        .waddr (ram_waddr),
        .wdata (ram_wdata),
        .raddr (inst_addr[DEPTH_LOG2-1:0]),
        .rdata (ram_rdata)
    );

    assign addr_in_range = (inst_addr[ADDR_W-1:DEPTH_LOG2] == '0);
    assign busy          = (state_q != LD_IDLE);
    assign ld_ready      = (state_q == LD_LOAD);
    assign ld_done       = (state_q == LD_FLUSH) | zero_done_q;
    assign core_rst_n    = core_rst_q;
    assign inst_data     = (busy || !addr_in_range) ? '0 : ram_rdata;

endmodule

// File: tb/tb_inst_mem_ctrl.sv
// Directed self-checking bench for inst_mem_ctrl.
// Inputs change 1 time unit after posedge; outputs sampled there too.
module tb_inst_mem_ctrl;

    localparam int DL2 = 10;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [31:0]   inst_addr = '0;
    logic [31:0]   inst_data;
    logic          ld_start = 1'b0;
    logic [DL2:0]  ld_words = '0;
    logic          ld_valid = 1'b0;
    logic [7:0]    ld_byte = '0;
    logic          ld_ready;
    logic          ld_done;
    logic          busy;
    logic          core_rst_n;

    int checks = 0;
    int failures = 0;

    inst_mem_ctrl dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .inst_addr  (inst_addr),
        .inst_data  (inst_data),
        .ld_start   (ld_start),
        .ld_words   (ld_words),
        .ld_valid   (ld_valid),
        .ld_byte    (ld_byte),
        .ld_ready   (ld_ready),
        .ld_done    (ld_done),
        .busy       (busy),
        .core_rst_n (core_rst_n)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_start(input logic [DL2:0] n);
        ld_words = n;
        ld_start = 1'b1;
        tick();
        ld_start = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b);
        int n;
        ld_valid = 1'b1;
        ld_byte  = b;
        n = 0;
        while (!ld_ready && n < 20) begin
            tick();
            n++;
        end
        if (!ld_ready) begin
            checks++;
            failures++;
            $display("FAIL send_byte ready timeout got=%0b exp=1", ld_ready);
        end
        tick();
        ld_valid = 1'b0;
    endtask

    task automatic set_addr(input logic [31:0] a);
        inst_addr = a;
        #1;
    endtask

    task automatic test_reset();
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if ({busy, ld_ready, ld_done, core_rst_n} !== 4'b0000) begin
            failures++;
            $display("FAIL reset_hold got=%b exp=0000",
                     {busy, ld_ready, ld_done, core_rst_n});
        end
        rst_n = 1'b1;
        #1;
        checks++;
        if (core_rst_n !== 1'b0) begin
            failures++;
            $display("FAIL reset_core_low got=%b exp=0", core_rst_n);
        end
        tick();
        checks++;
        if ({busy, ld_ready, ld_done, core_rst_n} !== 4'b0001) begin
            failures++;
            $display("FAIL reset_release got=%b exp=0001",
                     {busy, ld_ready, ld_done, core_rst_n});
        end
    endtask

    task automatic test_load2();
        logic [7:0] bytes [8] = '{8'h13, 8'h00, 8'h50, 8'h00,
                                  8'h93, 8'h00, 8'hA0, 8'h00};
        set_addr(32'd0);
        do_start(11'd2);
        checks++;
        if ({busy, ld_ready, core_rst_n} !== 3'b110 || inst_data !== 32'd0) begin
            failures++;
            $display("FAIL load2_enter got=%b/%h exp=110/0",
                     {busy, ld_ready, core_rst_n}, inst_data);
        end
        foreach (bytes[i]) send_byte(bytes[i]);
        checks++;
        if ({ld_done, core_rst_n, ld_ready} !== 3'b100) begin
            failures++;
            $display("FAIL load2_flush got=%b exp=100",
                     {ld_done, core_rst_n, ld_ready});
        end
        tick();
        checks++;
        if ({ld_done, core_rst_n, busy} !== 3'b010) begin
            failures++;
            $display("FAIL load2_after got=%b exp=010",
                     {ld_done, core_rst_n, busy});
        end
        set_addr(32'd0);
        checks++;
        if (inst_data !== 32'h0050_0013) begin
            failures++;
            $display("FAIL load2_w0 got=%h exp=00500013", inst_data);
        end
        set_addr(32'd1);
        checks++;
        if (inst_data !== 32'h00A0_0093) begin
            failures++;
            $display("FAIL load2_w1 got=%h exp=00a00093", inst_data);
        end
    endtask

    task automatic test_gapped();
        logic [7:0] bytes [8] = '{8'h13, 8'h00, 8'h50, 8'h00,
                                  8'h93, 8'h00, 8'hA0, 8'h00};
        logic       seen_nz;
        do_start(11'd2);
        repeat (8) send_byte(8'h5A);
        tick();
        set_addr(32'd1);
        checks++;
        if (inst_data !== 32'h5A5A_5A5A) begin
            failures++;
            $display("FAIL gap_pre got=%h exp=5a5a5a5a", inst_data);
        end
        set_addr(32'd0);
        seen_nz = 1'b0;
        do_start(11'd2);
        foreach (bytes[i]) begin
            send_byte(bytes[i]);
            if (i != 7) begin
                if (inst_data !== 32'd0) seen_nz = 1'b1;
                tick();
                tick();
            end
        end
        checks++;
        if (seen_nz || ld_done !== 1'b1) begin
            failures++;
            $display("FAIL gap_busy got=%b/%b exp=0/1", seen_nz, ld_done);
        end
        tick();
        set_addr(32'd0);
        checks++;
        if (inst_data !== 32'h0050_0013) begin
            failures++;
            $display("FAIL gap_w0 got=%h exp=00500013", inst_data);
        end
        set_addr(32'd1);
        checks++;
        if (inst_data !== 32'h00A0_0093) begin
            failures++;
            $display("FAIL gap_w1 got=%h exp=00a00093", inst_data);
        end
    endtask

    task automatic test_zero_words();
        do_start(11'd0);
        checks++;
        if ({ld_done, ld_ready, busy} !== 3'b100) begin
            failures++;
            $display("FAIL zero_pulse got=%b exp=100", {ld_done, ld_ready, busy});
        end
        ld_valid = 1'b1;
        ld_byte  = 8'hFF;
        tick();
        checks++;
        if ({ld_done, ld_ready, busy} !== 3'b000) begin
            failures++;
            $display("FAIL zero_after got=%b exp=000", {ld_done, ld_ready, busy});
        end
        repeat (6) tick();
        ld_valid = 1'b0;
        set_addr(32'd0);
        checks++;
        if (inst_data !== 32'h0050_0013) begin
            failures++;
            $display("FAIL zero_nowrite got=%h exp=00500013", inst_data);
        end
    endtask

    task automatic test_abort();
        logic [7:0] bytes [4] = '{8'hAA, 8'hBB, 8'hCC, 8'hDD};
        do_start(11'd2);
        for (int i = 1; i <= 5; i++) send_byte(8'(i));
        do_start(11'd1);
        checks++;
        if ({ld_done, ld_ready} !== 2'b01) begin
            failures++;
            $display("FAIL abort_restart got=%b exp=01", {ld_done, ld_ready});
        end
        foreach (bytes[i]) send_byte(bytes[i]);
        checks++;
        if (ld_done !== 1'b1) begin
            failures++;
            $display("FAIL abort_done got=%b exp=1", ld_done);
        end
        tick();
        set_addr(32'd0);
        checks++;
        if (inst_data !== 32'hDDCC_BBAA) begin
            failures++;
            $display("FAIL abort_w0 got=%h exp=ddccbbaa", inst_data);
        end
        set_addr(32'd1);
        checks++;
        if (inst_data !== 32'h00A0_0093) begin
            failures++;
            $display("FAIL abort_w1 got=%h exp=00a00093", inst_data);
        end
    endtask

    task automatic test_range_reset();
        logic done_seen;
        set_addr(32'd1024);
        checks++;
        if (inst_data !== 32'd0) begin
            failures++;
            $display("FAIL range_1024 got=%h exp=0", inst_data);
        end
        set_addr(32'h8000_0000);
        checks++;
        if (inst_data !== 32'd0) begin
            failures++;
            $display("FAIL range_msb got=%h exp=0", inst_data);
        end
        do_start(11'd2);
        for (int i = 1; i <= 6; i++) send_byte(8'(i));
        rst_n = 1'b0;
        #1;
        checks++;
        if ({busy, ld_ready, ld_done, core_rst_n} !== 4'b0000) begin
            failures++;
            $display("FAIL midrst_idle got=%b exp=0000",
                     {busy, ld_ready, ld_done, core_rst_n});
        end
        tick();
        rst_n = 1'b1;
        done_seen = 1'b0;
        repeat (4) begin
            tick();
            if (ld_done !== 1'b0) done_seen = 1'b1;
        end
        checks++;
        if (done_seen) begin
            failures++;
            $display("FAIL midrst_nodone got=%b exp=0", done_seen);
        end
        set_addr(32'd1);
        checks++;
        if (inst_data !== 32'h00A0_0093) begin
            failures++;
            $display("FAIL midrst_w1 got=%h exp=00a00093", inst_data);
        end
        set_addr(32'd0);
        checks++;
        if (inst_data !== 32'h0403_0201) begin
            failures++;
            $display("FAIL midrst_w0 got=%h exp=04030201", inst_data);
        end
    endtask

    task automatic test_wrap();
        logic [31:0] w;
        do_start(11'd1025);
        for (int i = 0; i <= 1024; i++) begin
            w = 32'(i);
            for (int j = 0; j < 4; j++) send_byte(w[j*8 +: 8]);
        end
        checks++;
        if (ld_done !== 1'b1) begin
            failures++;
            $display("FAIL wrap_done got=%b exp=1", ld_done);
        end
        tick();
        set_addr(32'd5);
        checks++;
        if (inst_data !== 32'd5) begin
            failures++;
            $display("FAIL wrap_w5 got=%h exp=5", inst_data);
        end
        set_addr(32'd0);
        checks++;
        if (inst_data !== 32'd1024) begin
            failures++;
            $display("FAIL wrap_w0 got=%h exp=400", inst_data);
        end
        set_addr(32'd1023);
        checks++;
        if (inst_data !== 32'd1023) begin
            failures++;
            $display("FAIL wrap_w1023 got=%h exp=3ff", inst_data);
        end
    endtask

    initial begin
        test_reset();
        test_load2();
        test_gapped();
        test_zero_words();
        test_abort();
        test_range_reset();
        test_wrap();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
